// File: rtl/gray_position_tracker.sv
// gray_position_tracker: synchronises an asynchronous Gray-coded input,
// converts it to binary, and tracks single-step motion as a wrapping
// position count. Multi-bit jumps are flagged, counted, and re-locked.
module gray_position_tracker #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     g_in,
  input  logic             en,
  input  logic             clr,
  output logic [W-1:0]     bin,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             valid,
  output logic             step_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     g_s1_q, g_s2_q;
  logic [W-1:0]     bin_q, bin_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             step_pulse_q, step_pulse_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [W-1:0]     b_new_c;
  logic [W-1:0]     delta_c;

  // Two-flop synchroniser; runs every cycle regardless of en/clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_s1_q <= '0;
      g_s2_q <= '0;
    end else begin
      g_s1_q <= g_in;
      g_s2_q <= g_s1_q;
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_new_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      b_new_c[i] = ^(g_s2_q >> i);
    end
  end

  // Modular distance from the last accepted code; 1 is up, all-ones is down.
  always_comb begin
    delta_c = b_new_c - bin_q;
  end

  // Tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      bin_q        <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b1;
      valid_q      <= 1'b0;
      step_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      valid_q      <= valid_d;
      step_pulse_q <= step_pulse_d;
      err_pulse_q  <= err_pulse_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state logic: clr wins, otherwise capture in INIT or classify the step in TRACK.
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    valid_d      = valid_q;
    step_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (clr) begin
      pos_d     = '0;
      err_cnt_d = '0;
      dir_d     = 1'b1;
      valid_d   = 1'b0;
      state_d   = ST_INIT;
    end else if (en) begin
      unique case (state_q)
        ST_INIT: begin
          bin_d   = b_new_c;
          valid_d = 1'b1;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (delta_c == W'(1)) begin
            pos_d        = pos_q + CNT_W'(1);
            dir_d        = 1'b1;
            step_pulse_d = 1'b1;
            bin_d        = b_new_c;
          end else if (delta_c == {W{1'b1}}) begin
            pos_d        = pos_q - CNT_W'(1);
            dir_d        = 1'b0;
            step_pulse_d = 1'b1;
            bin_d        = b_new_c;
          end else if (delta_c != '0) begin
            // Illegal jump: flag it and re-lock onto the new code.
            err_pulse_d = 1'b1;
            bin_d       = b_new_c;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign bin        = bin_q;
  assign pos        = pos_q;
  assign dir        = dir_q;
  assign valid      = valid_q;
  assign step_pulse = step_pulse_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_gray_position_tracker.sv
// Directed bench for gray_position_tracker: sweeps, wraps, errors,
// saturation, clear, asynchronous reset and enable gating.
module tb_gray_position_tracker;

  logic       clk;
  logic       rst_n;
  logic [3:0] g_in;
  logic       en;
  logic       clr;
  logic [3:0] bin;
  logic [7:0] pos;
  logic       dir;
  logic       valid;
  logic       step_pulse;
  logic       err_pulse;
  logic [3:0] err_cnt;

  int passed;
  int total;
  int n_step;
  int n_err;
  int n_both;

  gray_position_tracker #(.W(4), .CNT_W(8), .ERR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .g_in       (g_in),
    .en         (en),
    .clr        (clr),
    .bin        (bin),
    .pos        (pos),
    .dir        (dir),
    .valid      (valid),
    .step_pulse (step_pulse),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_count();
    tick();
    if (step_pulse === 1'b1) n_step++;
    if (err_pulse === 1'b1) n_err++;
    if (step_pulse === 1'b1 && err_pulse === 1'b1) n_both++;
  endtask

  task automatic clear_counts();
    n_step = 0;
    n_err  = 0;
    n_both = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; g_in = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bin, pos, dir, valid, step_pulse, err_pulse, err_cnt} !== {4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0})
      $display("FAIL reset_values got bin=%0d pos=%0d dir=%b valid=%b sp=%b ep=%b ec=%0d", bin, pos, dir, valid, step_pulse, err_pulse, err_cnt);
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    en = 1'b1;
    clear_counts();
    tick_count(); tick_count();
    total++; if (valid !== 1'b1) $display("FAIL init_valid got %b want 1", valid); else passed++;
    total++; if (pos !== 8'd0 || bin !== 4'd0) $display("FAIL init_pos_bin got pos=%0d bin=%0d want 0/0", pos, bin); else passed++;
    total++; if (n_step != 0 || n_err != 0) $display("FAIL init_pulses got step=%0d err=%0d want 0/0", n_step, n_err); else passed++;
  endtask

  task automatic test_up_sweep();
    clear_counts();
    for (int i = 1; i <= 20; i++) begin
      g_in = b2g(4'(i));
      tick_count();
    end
    repeat (3) tick_count();
    total++; if (n_step != 20) $display("FAIL up_steps got %0d want 20", n_step); else passed++;
    total++; if (n_err != 0 || n_both != 0) $display("FAIL up_errs got err=%0d both=%0d want 0/0", n_err, n_both); else passed++;
    total++; if (pos !== 8'd20) $display("FAIL up_pos got %0d want 20", pos); else passed++;
    total++; if (bin !== 4'd4) $display("FAIL up_bin got %0d want 4", bin); else passed++;
    total++; if (dir !== 1'b1) $display("FAIL up_dir got %b want 1", dir); else passed++;
  endtask

  task automatic test_down_sweep();
    clear_counts();
    for (int i = 1; i <= 25; i++) begin
      g_in = b2g(4'(4 - i));
      tick_count();
    end
    repeat (3) tick_count();
    total++; if (n_step != 25 || n_err != 0) $display("FAIL down_steps got step=%0d err=%0d want 25/0", n_step, n_err); else passed++;
    total++; if (pos !== 8'd251) $display("FAIL down_pos got %0d want 251", pos); else passed++;
    total++; if (dir !== 1'b0) $display("FAIL down_dir got %b want 0", dir); else passed++;
    total++; if (bin !== 4'd11) $display("FAIL down_bin got %0d want 11", bin); else passed++;
  endtask

  task automatic test_error_relock();
    clear_counts();
    for (int i = 1; i <= 10; i++) begin
      g_in = b2g(4'(11 - i));
      tick_count();
    end
    repeat (3) tick_count();
    total++; if (pos !== 8'd241 || bin !== 4'd1) $display("FAIL pre_jump got pos=%0d bin=%0d want 241/1", pos, bin); else passed++;
    clear_counts();
    g_in = 4'b0111;
    repeat (3) tick_count();
    total++; if (n_err != 1 || n_step != 0) $display("FAIL jump_pulses got err=%0d step=%0d want 1/0", n_err, n_step); else passed++;
    total++; if (err_cnt !== 4'd1) $display("FAIL jump_err_cnt got %0d want 1", err_cnt); else passed++;
    total++; if (pos !== 8'd241 || dir !== 1'b0) $display("FAIL jump_hold got pos=%0d dir=%b want 241/0", pos, dir); else passed++;
    total++; if (bin !== 4'd5) $display("FAIL jump_relock_bin got %0d want 5", bin); else passed++;
    clear_counts();
    g_in = 4'b0101;
    repeat (3) tick_count();
    total++; if (n_step != 1 || n_err != 0) $display("FAIL after_jump_step got step=%0d err=%0d want 1/0", n_step, n_err); else passed++;
    total++; if (pos !== 8'd242 || dir !== 1'b1 || bin !== 4'd6) $display("FAIL after_jump_state got pos=%0d dir=%b bin=%0d want 242/1/6", pos, dir, bin); else passed++;
  endtask

  task automatic test_saturate_clear();
    clear_counts();
    for (int i = 1; i <= 20; i++) begin
      g_in = b2g((i % 2) ? 4'd14 : 4'd6);
      tick_count();
    end
    repeat (3) tick_count();
    total++; if (n_err != 20 || n_step != 0) $display("FAIL sat_pulses got err=%0d step=%0d want 20/0", n_err, n_step); else passed++;
    total++; if (err_cnt !== 4'd15) $display("FAIL sat_err_cnt got %0d want 15", err_cnt); else passed++;
    total++; if (pos !== 8'd242 || bin !== 4'd6) $display("FAIL sat_hold got pos=%0d bin=%0d want 242/6", pos, bin); else passed++;
    // Park a new code in the synchroniser while disabled, then clear.
    en = 1'b0;
    g_in = b2g(4'd9);
    clear_counts();
    repeat (3) tick_count();
    total++; if (n_err != 0 || n_step != 0 || bin !== 4'd6) $display("FAIL en_low_hold got err=%0d step=%0d bin=%0d want 0/0/6", n_err, n_step, bin); else passed++;
    en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (pos !== 8'd0 || err_cnt !== 4'd0 || valid !== 1'b0 || dir !== 1'b1) $display("FAIL clr_state got pos=%0d ec=%0d valid=%b dir=%b want 0/0/0/1", pos, err_cnt, valid, dir); else passed++;
    total++; if (step_pulse !== 1'b0 || err_pulse !== 1'b0 || bin !== 4'd6) $display("FAIL clr_pulses got sp=%b ep=%b bin=%0d want 0/0/6", step_pulse, err_pulse, bin); else passed++;
    tick();
    total++; if (valid !== 1'b1 || bin !== 4'd9) $display("FAIL recapture got valid=%b bin=%0d want 1/9", valid, bin); else passed++;
    total++; if (step_pulse !== 1'b0 || err_pulse !== 1'b0 || pos !== 8'd0) $display("FAIL recapture_quiet got sp=%b ep=%b pos=%0d want 0/0/0", step_pulse, err_pulse, pos); else passed++;
  endtask

  task automatic test_async_reset_and_enable();
    clear_counts();
    g_in = b2g(4'd10); tick_count();
    g_in = b2g(4'd11); tick_count();
    g_in = b2g(4'd12); tick_count();
    tick_count();
    total++; if (pos !== 8'd2 || bin !== 4'd11) $display("FAIL mid_sweep got pos=%0d bin=%0d want 2/11", pos, bin); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bin, pos, dir, valid, step_pulse, err_pulse, err_cnt} !== {4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0})
      $display("FAIL async_reset got bin=%0d pos=%0d dir=%b valid=%b sp=%b ep=%b ec=%0d", bin, pos, dir, valid, step_pulse, err_pulse, err_cnt);
    else passed++;
    en = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    tick();
    total++; if (valid !== 1'b1 || bin !== 4'd12 || step_pulse !== 1'b0 || err_pulse !== 1'b0) $display("FAIL post_reset_capture got valid=%b bin=%0d sp=%b ep=%b want 1/12/0/0", valid, bin, step_pulse, err_pulse); else passed++;
    en = 1'b0;
    g_in = b2g(4'd14);
    clear_counts();
    repeat (3) tick_count();
    total++; if (n_err != 0 || n_step != 0 || bin !== 4'd12) $display("FAIL disabled_hold got err=%0d step=%0d bin=%0d want 0/0/12", n_err, n_step, bin); else passed++;
    en = 1'b1;
    tick();
    total++; if (err_pulse !== 1'b1 || step_pulse !== 1'b0 || err_cnt !== 4'd1 || bin !== 4'd14) $display("FAIL reenable_err got ep=%b sp=%b ec=%0d bin=%0d want 1/0/1/14", err_pulse, step_pulse, err_cnt, bin); else passed++;
    tick();
    total++; if (err_pulse !== 1'b0) $display("FAIL reenable_one_shot got ep=%b want 0", err_pulse); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clear_counts();
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_error_relock();
    test_saturate_clear();
    test_async_reset_and_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
